alu_pipe: RTL and testbench

Two-stage pipelined integer execution unit directly downstream of the reservation station. Accepts one ready operation per cycle from the station's issue port, computes the result, and broadcasts it on the ALU write-back bus. That bus feeds the reservation station's dependency update and the ROB. It never stalls the station and is flushed by `rob_clear`.

---
 rtl/alu_pipe_if.sv | 31 +++
 rtl/alu_pipe.sv | 110 +++++++++++
 tb/tb_alu_pipe.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: bundles the reservation-station issue port and the ALU write-back bus.
//   Issue port : alu_valid, alu_r1, alu_r2, alu_op, alu_rob_idx  (station -> ALU)
//   Write-back : alu_wb_valid, alu_wb_idx, alu_wb_value           (ALU -> station/ROB)
//   master modport is the station/consumer side, slave modport is the ALU side.
`timescale 1ns/1ps
interface alu_pipe_if #(
   parameter int unsigned RS_TYPE_BIT  = 5,
   parameter int unsigned ROB_SIZE_BIT = 4
);
   localparam int unsigned XLEN = 32;

   logic                    alu_valid;
   logic [XLEN-1:0]         alu_r1;
   logic [XLEN-1:0]         alu_r2;
   logic [RS_TYPE_BIT-1:0]  alu_op;
   logic [ROB_SIZE_BIT-1:0] alu_rob_idx;

   logic                    alu_wb_valid;
   logic [ROB_SIZE_BIT-1:0] alu_wb_idx;
   logic [XLEN-1:0]         alu_wb_value;

   modport master (
      output alu_valid, alu_r1, alu_r2, alu_op, alu_rob_idx,
      input  alu_wb_valid, alu_wb_idx, alu_wb_value
   );

   modport slave (
      input  alu_valid, alu_r1, alu_r2, alu_op, alu_rob_idx,
      output alu_wb_valid, alu_wb_idx, alu_wb_value
   );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer execution unit.
//   E1 registers the issued operation, E2 computes and registers the write-back.
// Ports:
//   clk_in    : system clock, rising edge
//   rst_in    : asynchronous active-low reset
//   rdy_in    : global enable; all state holds while low
//   rob_clear : synchronous flush of in-flight operations
//   bus       : issue port in, write-back bus out (alu_pipe_if.slave)
//   op_count  : results broadcast since reset, wraps
`timescale 1ns/1ps
module alu_pipe #(
   parameter int unsigned RS_TYPE_BIT  = 5,
   parameter int unsigned ROB_SIZE_BIT = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_clear,
   alu_pipe_if.slave   bus,
   output logic [31:0] op_count
);
   localparam int unsigned XLEN    = 32;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned SHAMT_W = 5;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
      OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7,
      OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_EQ  = 4'd10, OP_NE  = 4'd11,
      OP_LT   = 4'd12, OP_GE   = 4'd13, OP_LTU = 4'd14, OP_GEU = 4'd15
   } alu_op_e;

   logic                    e1_valid;
   alu_op_e                 e1_op;
   logic [XLEN-1:0]         e1_r1;
   logic [XLEN-1:0]         e1_r2;
   logic [ROB_SIZE_BIT-1:0] e1_idx;

   logic                    wb_valid;
   logic [ROB_SIZE_BIT-1:0] wb_idx;
   logic [XLEN-1:0]         wb_value;

   logic [XLEN-1:0]         result_c;
   logic [SHAMT_W-1:0]      shamt_c;

   // Only the low four opcode bits are decoded; the rest are deliberately dropped.
   generate
      if (RS_TYPE_BIT > OP_W) begin : g_op_hi
         logic unused_op_hi;
         assign unused_op_hi = ^bus.alu_op[RS_TYPE_BIT-1:OP_W];
      end
   endgenerate

   // E2 datapath: result of the operation held in E1.
   always_comb begin
      result_c = '0;
      shamt_c  = e1_r2[SHAMT_W-1:0];
      case (e1_op)
         OP_ADD:  result_c = e1_r1 + e1_r2;
         OP_SUB:  result_c = e1_r1 - e1_r2;
         OP_AND:  result_c = e1_r1 & e1_r2;
         OP_OR:   result_c = e1_r1 | e1_r2;
         OP_XOR:  result_c = e1_r1 ^ e1_r2;
         OP_SLL:  result_c = e1_r1 << shamt_c;
         OP_SRL:  result_c = e1_r1 >> shamt_c;
         OP_SRA:  result_c = XLEN'($signed(e1_r1) >>> shamt_c);
         OP_SLT:  result_c = XLEN'($signed(e1_r1) < $signed(e1_r2));
         OP_SLTU: result_c = XLEN'(e1_r1 < e1_r2);
         OP_EQ:   result_c = XLEN'(e1_r1 == e1_r2);
         OP_NE:   result_c = XLEN'(e1_r1 != e1_r2);
         OP_LT:   result_c = XLEN'($signed(e1_r1) < $signed(e1_r2));
         OP_GE:   result_c = XLEN'($signed(e1_r1) >= $signed(e1_r2));
         OP_LTU:  result_c = XLEN'(e1_r1 < e1_r2);
         OP_GEU:  result_c = XLEN'(e1_r1 >= e1_r2);
         default: result_c = '0;
      endcase
   end

   // Pipeline registers and broadcast counter; a flush kills both valid stages
   // and suppresses counting of the result being killed at that edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         e1_valid <= 1'b0;
         e1_op    <= OP_ADD;
         e1_r1    <= '0;
         e1_r2    <= '0;
         e1_idx   <= '0;
         wb_valid <= 1'b0;
         wb_idx   <= '0;
         wb_value <= '0;
         op_count <= '0;
      end else if (rdy_in) begin
         e1_valid <= bus.alu_valid & ~rob_clear;
         e1_op    <= alu_op_e'(bus.alu_op[OP_W-1:0]);
         e1_r1    <= bus.alu_r1;
         e1_r2    <= bus.alu_r2;
         e1_idx   <= bus.alu_rob_idx;
         wb_valid <= e1_valid & ~rob_clear;
         wb_idx   <= e1_idx;
         wb_value <= result_c;
         if (wb_valid && !rob_clear) begin
            op_count <= op_count + 32'd1;
         end
      end
   end

   assign bus.alu_wb_valid = wb_valid;
   assign bus.alu_wb_idx   = wb_idx;
   assign bus.alu_wb_value = wb_value;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe.
`timescale 1ns/1ps
module tb_alu_pipe;
   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        rob_clear;
   logic [31:0] op_count;

   int n_checks;
   int n_fail;
   int exp_cnt;

   alu_pipe_if #(.RS_TYPE_BIT(5), .ROB_SIZE_BIT(4)) bus ();

   alu_pipe #(.RS_TYPE_BIT(5), .ROB_SIZE_BIT(4)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .rob_clear (rob_clear),
      .bus       (bus),
      .op_count  (op_count)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Advance one rising edge; return 1 ns after it.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_issue(input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] idx);
      bus.alu_valid   = 1'b1;
      bus.alu_op      = op;
      bus.alu_r1      = a;
      bus.alu_r2      = b;
      bus.alu_rob_idx = idx;
   endtask

   task automatic set_idle();
      bus.alu_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
      bus.alu_valid = 1'b0; bus.alu_op = '0; bus.alu_r1 = '0;
      bus.alu_r2 = '0; bus.alu_rob_idx = '0;
      tick(); tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0h expected 0", bus.alu_wb_valid); end
      n_checks++;
      if (bus.alu_wb_idx !== 4'd0) begin n_fail++; $display("FAIL reset_wb_idx: got %0h expected 0", bus.alu_wb_idx); end
      n_checks++;
      if (bus.alu_wb_value !== 32'd0) begin n_fail++; $display("FAIL reset_wb_value: got %0h expected 0", bus.alu_wb_value); end
      n_checks++;
      if (op_count !== 32'd0) begin n_fail++; $display("FAIL reset_op_count: got %0h expected 0", op_count); end
      rst_in = 1'b1;
      exp_cnt = 0;
      tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %0h expected 0", bus.alu_wb_valid); end
   endtask

   task automatic test_back_to_back();
      set_issue(5'd0, 32'd5, 32'd7, 4'd3);
      tick();
      set_issue(5'd1, 32'd5, 32'd7, 4'd4);
      tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b1 || bus.alu_wb_idx !== 4'd3 || bus.alu_wb_value !== 32'd12) begin
         n_fail++; $display("FAIL b2b_add: got v=%0h idx=%0h val=%0h expected v=1 idx=3 val=c",
                            bus.alu_wb_valid, bus.alu_wb_idx, bus.alu_wb_value);
      end
      set_idle();
      tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b1 || bus.alu_wb_idx !== 4'd4 || bus.alu_wb_value !== 32'hFFFF_FFFE) begin
         n_fail++; $display("FAIL b2b_sub: got v=%0h idx=%0h val=%0h expected v=1 idx=4 val=fffffffe",
                            bus.alu_wb_valid, bus.alu_wb_idx, bus.alu_wb_value);
      end
      tick();
      exp_cnt += 2;
      n_checks++;
      if (bus.alu_wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0h expected 0", bus.alu_wb_valid); end
      n_checks++;
      if (op_count !== 32'd2) begin n_fail++; $display("FAIL b2b_op_count: got %0d expected 2", op_count); end
   endtask

   task automatic test_shift_compare();
      logic [4:0]  ops  [14] = '{5'd7, 5'd9, 5'd8, 5'd15, 5'd5, 5'd6, 5'd3,
                                 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'h10, 5'h11};
      logic [31:0] a    [14] = '{32'h8000_0000, 32'd1, 32'd1, 32'd0, 32'd1, 32'h8000_0000, 32'hF0,
                                 32'd5, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] b    [14] = '{32'd33, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h24, 32'd31, 32'h0F,
                                 32'd5, 32'd5, 32'd0, 32'd1, 32'd0, 32'd2, 32'd1};
      logic [31:0] expv [14] = '{32'hC000_0000, 32'd1, 32'd0, 32'd1, 32'h10, 32'd1, 32'hFF,
                                 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF};
      for (int i = 0; i < 14; i++) begin
         set_issue(ops[i], a[i], b[i], 4'(i));
         tick();
         set_idle();
         tick();
         n_checks++;
         if (bus.alu_wb_valid !== 1'b1 || bus.alu_wb_idx !== 4'(i) || bus.alu_wb_value !== expv[i]) begin
            n_fail++; $display("FAIL sweep_%0d op=%0h: got v=%0h idx=%0h val=%0h expected v=1 idx=%0h val=%0h",
                               i, ops[i], bus.alu_wb_valid, bus.alu_wb_idx, bus.alu_wb_value, i, expv[i]);
         end
         tick();
         exp_cnt++;
      end
      n_checks++;
      if (op_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL sweep_op_count: got %0d expected %0d", op_count, exp_cnt); end
   endtask

   task automatic test_stall();
      set_issue(5'd2, 32'h0000_F0F0, 32'h0000_FF00, 4'd7);
      tick();
      set_idle();
      tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b1 || bus.alu_wb_idx !== 4'd7 || bus.alu_wb_value !== 32'h0000_F000) begin
         n_fail++; $display("FAIL stall_first: got v=%0h idx=%0h val=%0h expected v=1 idx=7 val=f000",
                            bus.alu_wb_valid, bus.alu_wb_idx, bus.alu_wb_value);
      end
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bus.alu_wb_valid !== 1'b1 || bus.alu_wb_idx !== 4'd7 || bus.alu_wb_value !== 32'h0000_F000) begin
            n_fail++; $display("FAIL stall_hold_%0d: got v=%0h idx=%0h val=%0h expected v=1 idx=7 val=f000",
                               i, bus.alu_wb_valid, bus.alu_wb_idx, bus.alu_wb_value);
         end
         n_checks++;
         if (op_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL stall_count_%0d: got %0d expected %0d", i, op_count, exp_cnt); end
      end
      rdy_in = 1'b1;
      tick();
      exp_cnt++;
      n_checks++;
      if (op_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL stall_release_count: got %0d expected %0d", op_count, exp_cnt); end
      n_checks++;
      if (bus.alu_wb_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid: got %0h expected 0", bus.alu_wb_valid); end
   endtask

   task automatic test_flush();
      set_issue(5'd0, 32'd10, 32'd20, 4'd6);
      tick();
      set_issue(5'd3, 32'd1, 32'd2, 4'd1);
      tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b1 || bus.alu_wb_idx !== 4'd6 || bus.alu_wb_value !== 32'd30) begin
         n_fail++; $display("FAIL flush_pre: got v=%0h idx=%0h val=%0h expected v=1 idx=6 val=1e",
                            bus.alu_wb_valid, bus.alu_wb_idx, bus.alu_wb_value);
      end
      set_issue(5'd0, 32'd1, 32'd1, 4'd5);
      rob_clear = 1'b1;
      tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill_e1: got %0h expected 0", bus.alu_wb_valid); end
      n_checks++;
      if (op_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL flush_no_count: got %0d expected %0d", op_count, exp_cnt); end
      rob_clear = 1'b0;
      set_issue(5'd4, 32'd3, 32'd1, 4'd2);
      tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill_issue: got %0h expected 0", bus.alu_wb_valid); end
      set_idle();
      tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b1 || bus.alu_wb_idx !== 4'd2 || bus.alu_wb_value !== 32'd2) begin
         n_fail++; $display("FAIL flush_post: got v=%0h idx=%0h val=%0h expected v=1 idx=2 val=2",
                            bus.alu_wb_valid, bus.alu_wb_idx, bus.alu_wb_value);
      end
      tick();
      exp_cnt++;
      n_checks++;
      if (op_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL flush_count: got %0d expected %0d", op_count, exp_cnt); end
   endtask

   task automatic test_idle_gaps();
      logic pat [3] = '{1'b1, 1'b0, 1'b1};
      logic exp_v;
      for (int k = 0; k < 6; k++) begin
         if (k < 3 && pat[k]) set_issue(5'd0, 32'(k), 32'(k), 4'(k));
         else set_idle();
         tick();
         exp_v = (k >= 1 && k <= 3) ? pat[k-1] : 1'b0;
         n_checks++;
         if (bus.alu_wb_valid !== exp_v) begin n_fail++; $display("FAIL gap_%0d: got %0h expected %0h", k, bus.alu_wb_valid, exp_v); end
      end
      exp_cnt += 2;
      n_checks++;
      if (op_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL gap_count: got %0d expected %0d", op_count, exp_cnt); end
   endtask

   task automatic test_async_reset();
      set_issue(5'd0, 32'd1, 32'd1, 4'd9);
      tick();
      set_idle();
      tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b1 || bus.alu_wb_value !== 32'd2) begin
         n_fail++; $display("FAIL areset_pre: got v=%0h val=%0h expected v=1 val=2", bus.alu_wb_valid, bus.alu_wb_value);
      end
      #2;
      rst_in = 1'b0;
      #1;
      n_checks++;
      if (bus.alu_wb_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0h expected 0", bus.alu_wb_valid); end
      n_checks++;
      if (bus.alu_wb_value !== 32'd0) begin n_fail++; $display("FAIL areset_value: got %0h expected 0", bus.alu_wb_value); end
      n_checks++;
      if (op_count !== 32'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", op_count); end
      @(negedge clk_in);
      rst_in = 1'b1;
      exp_cnt = 0;
      set_issue(5'd1, 32'd9, 32'd4, 4'd1);
      tick();
      set_idle();
      tick();
      n_checks++;
      if (bus.alu_wb_valid !== 1'b1 || bus.alu_wb_idx !== 4'd1 || bus.alu_wb_value !== 32'd5) begin
         n_fail++; $display("FAIL areset_recover: got v=%0h idx=%0h val=%0h expected v=1 idx=1 val=5",
                            bus.alu_wb_valid, bus.alu_wb_idx, bus.alu_wb_value);
      end
      tick();
      exp_cnt++;
      n_checks++;
      if (op_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL areset_recover_count: got %0d expected %0d", op_count, exp_cnt); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_cnt  = 0;
      test_reset();
      test_back_to_back();
      test_shift_compare();
      test_stall();
      test_flush();
      test_idle_gaps();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
